// File: rtl/dco_latch_bank_ctrl.sv
// Write sequencer for latch-based DCO tuning banks: frames each latch enable
// pulse with setup/hold margins on a shared, flop-driven latch data bus.
module dco_latch_bank_ctrl #(
  parameter int NBANKS    = 3,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               req_valid,
  output logic                                               req_ready,
  input  logic [((NBANKS > 1) ? $clog2(NBANKS) : 1)-1:0]     req_bank,
  input  logic [DW-1:0]                                      req_data,
  output logic [DW-1:0]                                      lat_d,
  output logic [NBANKS-1:0]                                  lat_g,
  output logic                                               busy,
  output logic                                               done,
  output logic                                               err
);

  localparam int BW   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int MAXC = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [BW-1:0]       bank, bank_nx;
  logic [DW-1:0]       lat_d_nx;
  logic [NBANKS-1:0]   lat_g_nx;
  logic                done_nx, err_nx;
  logic                idle, accept, bank_ok, expire;

  assign idle      = (state == IDLE);
  // Ready is masked during reset so every output reads zero while rst_n is low.
  assign req_ready = idle && rst_n;
  assign busy      = !idle;
  assign accept    = req_valid && req_ready;
  assign bank_ok   = int'(req_bank) < NBANKS;
  assign expire    = (cnt == CW'(1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bank_nx  = bank;
    lat_d_nx = lat_d;
    lat_g_nx = lat_g;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        lat_g_nx = '0;
        if (accept) begin
          if (bank_ok) begin
            lat_d_nx = req_data;
            bank_nx  = req_bank;
            cnt_nx   = CW'(SETUP_CYC);
            state_nx = SETUP;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      SETUP: begin
        lat_g_nx = '0;
        if (expire) begin
          lat_g_nx = NBANKS'(1) << bank;
          cnt_nx   = CW'(PULSE_CYC);
          state_nx = OPEN;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      OPEN: begin
        if (expire) begin
          lat_g_nx = '0;
          cnt_nx   = CW'(HOLD_CYC);
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      HOLD: begin
        // Data stays put here so the latch hold check after G falls is met.
        lat_g_nx = '0;
        if (expire) begin
          cnt_nx   = '0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        lat_g_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bank  <= '0;
      lat_d <= '0;
      lat_g <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bank  <= bank_nx;
      lat_d <= lat_d_nx;
      lat_g <= lat_g_nx;
      done  <= done_nx;
      err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_dco_latch_bank_ctrl.sv
// Self-checking bench for dco_latch_bank_ctrl: directed scenarios plus a
// randomized run against a timestamp-based reference model.
module tb_dco_latch_bank_ctrl;

  localparam int NBANKS = 3;
  localparam int DW     = 8;
  localparam int S      = 2;
  localparam int P      = 2;
  localparam int H      = 1;
  localparam int T      = S + P + H;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic [1:0]        req_bank = '0;
  logic [DW-1:0]     req_data = '0;
  logic              req_ready, busy, done, err;
  logic [DW-1:0]     lat_d;
  logic [NBANKS-1:0] lat_g;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: edge of last legal acceptance, its bank/data, last illegal edge.
  int            m_k     = -1000;
  int            m_bank  = 0;
  int            m_errk  = -1000;
  logic [DW-1:0] m_data  = '0;

  dco_latch_bank_ctrl #(
    .NBANKS(NBANKS), .DW(DW), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_bank(req_bank), .req_data(req_data), .lat_d(lat_d), .lat_g(lat_g),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // lat_d may only move on an accepted legal request; lat_g one-hot-or-zero; done/err exclusive.
  logic [DW-1:0] prev_d, prev_req_d;
  logic          prev_acc;
  logic          prev_live = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_live) begin
      n_cmp++;
      if (prev_acc ? (lat_d !== prev_req_d) : (lat_d !== prev_d)) begin
        n_bad++;
        $display("FAIL lat_d_stable: lat_d=%h required %h", lat_d, prev_acc ? prev_req_d : prev_d);
      end
      n_cmp++;
      if (!$onehot0(lat_g) || (done && err)) begin
        n_bad++;
        $display("FAIL onehot_excl: lat_g=%b done=%b err=%b required onehot0 and not both", lat_g, done, err);
      end
    end
    prev_live  = rst_n;
    prev_d     = lat_d;
    prev_req_d = req_data;
    prev_acc   = req_valid && req_ready && (int'(req_bank) < NBANKS);
  end

  task test_reset;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, busy, done, err, lat_d, lat_g} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: outputs=%h required 0", {req_ready, busy, done, err, lat_d, lat_g});
    end
    @(negedge clk); @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", req_ready, busy);
    end
    n_cmp++;
    if ({done, err, lat_d, lat_g} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {done, err, lat_d, lat_g});
    end
  endtask

  task test_single;
    logic [NBANKS-1:0] eg;
    @(posedge clk); #1;
    req_valid = 1'b1; req_bank = 2'd1; req_data = 8'hA5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      eg = (i >= 2 && i < 4) ? 3'b010 : 3'b000;
      n_cmp++;
      if (lat_g !== eg) begin
        n_bad++; $display("FAIL single_lat_g[%0d]: got %b want %b", i, lat_g, eg);
      end
      n_cmp++;
      if (lat_d !== 8'hA5) begin
        n_bad++; $display("FAIL single_lat_d[%0d]: got %h want a5", i, lat_d);
      end
      n_cmp++;
      if (done !== (i == 5)) begin
        n_bad++; $display("FAIL single_done[%0d]: got %b want %b", i, done, (i == 5));
      end
      n_cmp++;
      if (req_ready !== (i >= 5)) begin
        n_bad++; $display("FAIL single_ready[%0d]: got %b want %b", i, req_ready, (i >= 5));
      end
      @(posedge clk); #1;
      req_data = 8'($urandom);
      req_bank = 2'($urandom_range(0, 3));
    end
  endtask

  task test_back_to_back;
    logic [NBANKS-1:0] eg;
    logic [DW-1:0]     ed;
    @(posedge clk); #1;
    req_valid = 1'b1; req_bank = 2'd0; req_data = 8'h3C;
    @(posedge clk); #1;
    req_bank = 2'd2; req_data = 8'hC3;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      eg = (i >= 2 && i < 4) ? 3'b001 : ((i >= 8 && i < 10) ? 3'b100 : 3'b000);
      ed = (i < 6) ? 8'h3C : 8'hC3;
      n_cmp++;
      if (lat_g !== eg) begin
        n_bad++; $display("FAIL b2b_lat_g[%0d]: got %b want %b", i, lat_g, eg);
      end
      n_cmp++;
      if (lat_d !== ed) begin
        n_bad++; $display("FAIL b2b_lat_d[%0d]: got %h want %h", i, lat_d, ed);
      end
      n_cmp++;
      if (done !== (i == 5 || i == 11)) begin
        n_bad++; $display("FAIL b2b_done[%0d]: got %b want %b", i, done, (i == 5 || i == 11));
      end
      n_cmp++;
      if (req_ready !== (i == 5 || i >= 11)) begin
        n_bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, req_ready, (i == 5 || i >= 11));
      end
      @(posedge clk); #1;
      if (i == 5) req_valid = 1'b0;
    end
  endtask

  task test_illegal;
    @(posedge clk); #1;
    req_valid = 1'b1; req_bank = 2'd3; req_data = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL illegal_pre_ready: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (err !== (i == 0)) begin
        n_bad++; $display("FAIL illegal_err[%0d]: got %b want %b", i, err, (i == 0));
      end
      n_cmp++;
      if (lat_g !== 3'b000 || done !== 1'b0) begin
        n_bad++; $display("FAIL illegal_lat_g[%0d]: got g=%b done=%b want 0 0", i, lat_g, done);
      end
      n_cmp++;
      if (lat_d !== 8'hC3) begin
        n_bad++; $display("FAIL illegal_lat_d[%0d]: got %h want c3", i, lat_d);
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin
        n_bad++; $display("FAIL illegal_ready[%0d]: got %b want 1", i, req_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task test_reset_open;
    logic [NBANKS-1:0] eg;
    @(posedge clk); #1;
    req_valid = 1'b1; req_bank = 2'd2; req_data = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (lat_g !== 3'b100) begin
      n_bad++; $display("FAIL rst_open_pre: got %b want 100", lat_g);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (lat_g !== 3'b000 || lat_d !== 8'h00) begin
      n_bad++; $display("FAIL rst_open_async: got g=%b d=%h want 000 00", lat_g, lat_d);
    end
    n_cmp++;
    if ({busy, done, err} !== 3'b000) begin
      n_bad++; $display("FAIL rst_open_ctrl: got %b want 000", {busy, done, err});
    end
    @(negedge clk); @(negedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_bank = 2'd2; req_data = 8'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      eg = (i >= 2 && i < 4) ? 3'b100 : 3'b000;
      n_cmp++;
      if (lat_g !== eg || lat_d !== 8'h11) begin
        n_bad++; $display("FAIL rst_rewrite[%0d]: got g=%b d=%h want %b 11", i, lat_g, lat_d, eg);
      end
      n_cmp++;
      if (done !== (i == 5) || req_ready !== (i >= 5)) begin
        n_bad++; $display("FAIL rst_rewrite_hs[%0d]: got done=%b rdy=%b want %b %b", i, done, req_ready, (i == 5), (i >= 5));
      end
      @(posedge clk); #1;
    end
  endtask

  task test_random;
    int                writes, cycles, n;
    logic              eb, ed, ee;
    logic [NBANKS-1:0] eg;
    rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #3 rst_n = 1'b1;
    m_k = -1000; m_errk = -1000; m_data = '0; m_bank = 0;
    writes = 0; cycles = 0;
    @(posedge clk); #1;
    req_valid = ($urandom_range(0, 9) < 6);
    req_bank  = 2'($urandom_range(0, 3));
    req_data  = 8'($urandom);
    while (writes < 1000 && cycles < 20000) begin
      @(negedge clk);
      n = cyc;
      cycles++;
      eb = (n >= m_k) && (n < m_k + T);
      eg = (n >= m_k + S && n < m_k + S + P) ? NBANKS'(1 << m_bank) : '0;
      ed = (n == m_k + T);
      ee = (n == m_errk);
      n_cmp++;
      if (busy !== eb || req_ready !== !eb) begin
        n_bad++; $display("FAIL rnd_busy@%0d: got busy=%b rdy=%b want %b %b", n, busy, req_ready, eb, !eb);
      end
      n_cmp++;
      if (lat_g !== eg) begin
        n_bad++; $display("FAIL rnd_lat_g@%0d: got %b want %b", n, lat_g, eg);
      end
      n_cmp++;
      if (lat_d !== m_data) begin
        n_bad++; $display("FAIL rnd_lat_d@%0d: got %h want %h", n, lat_d, m_data);
      end
      n_cmp++;
      if (done !== ed || err !== ee) begin
        n_bad++; $display("FAIL rnd_pulse@%0d: got done=%b err=%b want %b %b", n, done, err, ed, ee);
      end
      if (req_valid && !eb) begin
        if (int'(req_bank) < NBANKS) begin
          m_k = n + 1; m_bank = int'(req_bank); m_data = req_data; writes++;
        end else begin
          m_errk = n + 1;
        end
      end
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 9) < 6);
      req_bank  = 2'($urandom_range(0, 3));
      req_data  = 8'($urandom);
    end
    req_valid = 1'b0;
    n_cmp++;
    if (writes < 1000) begin
      n_bad++; $display("FAIL rnd_budget: got %0d writes want 1000", writes);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_illegal;
    test_reset_open;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
